// File: rtl/spi_sample_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sample_buffer_pkg                                                |
// | Widths and types shared between the SPI-side audio sample blocks.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_sample_buffer_pkg;
  localparam int SAMPLE_W = 16;
  localparam int BYTE_W   = 8;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } byte_phase_e;
endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | Register-array FIFO with wrapping pointers and a separate level.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo
  import spi_sample_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [AW:0]   c_lvl_one = (AW + 1)'(1);
  localparam logic [AW:0]   c_lvl_max = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_rd;
  logic          w_wr;

  assign full    = (r_level == c_lvl_max);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_rd = rd_en & ~empty;
  assign w_wr = wr_en & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (w_wr && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/spi_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sample_buffer                                                    |
// | Packs flash bytes into LE 16-bit samples, buffers them for I2S and   |
// | throttles the SPI reader through pausa.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_sample_buffer
  import spi_sample_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic                byte_valid,
  input  logic                sample_req,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                pausa,
  output logic [AW:0]         level,
  output logic                underrun,
  output logic                overflow
);
  localparam logic [AW:0] c_lvl_one = (AW + 1)'(1);
  localparam logic [AW:0] c_pausa_th = (AW + 1)'(DEPTH - 1);

  byte_phase_e         r_ph;
  logic [BYTE_W-1:0]   r_lo;
  logic [SAMPLE_W-1:0] r_sample_out;
  logic                r_pausa;
  logic                r_underrun;
  logic                r_overflow;

  logic                w_push;
  logic                w_pop_req;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic                w_full;
  logic                w_empty;
  logic [AW:0]         w_level;
  logic [AW:0]         w_level_nxt;
  logic [SAMPLE_W-1:0] w_head;

  assign w_push    = byte_valid & (r_ph == PH_HI) & ~flush;
  assign w_pop_req = sample_req & ~flush;
  assign w_push_ok = w_push & (~w_full | w_pop_req);
  assign w_pop_ok  = w_pop_req & ~w_empty;

  assign w_level_nxt = flush ? '0
                     : w_level + (w_push_ok ? c_lvl_one : '0) - (w_pop_ok ? c_lvl_one : '0);

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (w_push),
    .wr_data ({byte_in, r_lo}),
    .rd_en   (w_pop_req),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph <= PH_LO;
      r_lo <= '0;
    end else if (flush) begin
      r_ph <= PH_LO;
    end else if (byte_valid) begin
      if (r_ph == PH_LO) begin
        r_lo <= byte_in;
        r_ph <= PH_HI;
      end else begin
        r_ph <= PH_LO;
      end
    end
  end

  // sample_out deliberately survives a flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_out <= '0;
      r_pausa      <= 1'b0;
      r_underrun   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_pausa <= (w_level_nxt >= c_pausa_th);
      if (w_pop_req) r_sample_out <= w_empty ? '0 : w_head;
      if (flush) begin
        r_underrun <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_pop_req && w_empty)  r_underrun <= 1'b1;
        if (w_push && !w_push_ok)  r_overflow <= 1'b1;
      end
    end
  end

  assign sample_out = r_sample_out;
  assign pausa      = r_pausa;
  assign level      = w_level;
  assign underrun   = r_underrun;
  assign overflow   = r_overflow;
endmodule
`default_nettype wire
